// File: rtl/cr_huf_comp_st_rd_sched_pkg.sv
// Shared types and widths for the Huffman symbol-table read-out scheduler.
package cr_huf_comp_st_rd_sched_pkg;

  localparam int unsigned CREOLE_HC_SEQID_WIDTH              = 8;
  localparam int unsigned CREOLE_HC_SMALL_TABLE_XTR_BIT_SIZE = 12;
  localparam int unsigned ST_RD_XTR_W                        = CREOLE_HC_SMALL_TABLE_XTR_BIT_SIZE + 1;
  localparam int unsigned ST_RD_DAT_WIDTH                    = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    DRAIN,
    DONE,
    WAIT_CLR
  } e_st_rd_state;

  typedef struct packed {
    logic                       sym_val;
    logic [ST_RD_DAT_WIDTH-1:0] symbol;
    logic [7:0]                 extra;
    logic [3:0]                 extra_length;
    logic                       last;
  } s_st_rd_beat;

endpackage

// File: rtl/cr_huf_comp_st_rd_sched.sv
// Walks a latched symbol table through an indexed read port and streams it out over valid/ready.
// Optional statistics are built only when CR_HUF_COMP_ST_RD_SCHED_STATS_EN is defined.
module cr_huf_comp_st_rd_sched
  import cr_huf_comp_st_rd_sched_pkg::*;
#(
  parameter int unsigned DAT_WIDTH              = ST_RD_DAT_WIDTH,
  parameter int unsigned MAX_SYMBOL_TABLE_DEPTH = 584,
  localparam int unsigned IDX_W                 = $clog2(MAX_SYMBOL_TABLE_DEPTH + 1)
) (
  input  logic                             clk_gated,
  input  logic                             rst_n,
  input  logic                             sym_buf_full,
  input  logic [IDX_W-1:0]                 sym_buf_wr_ptr,
  input  logic                             st_build_error,
  input  logic [CREOLE_HC_SEQID_WIDTH-1:0] st_seq_id,
  input  logic [ST_RD_XTR_W-1:0]           st_extra_size_store,
  output logic [IDX_W-1:0]                 rd_idx,
  input  logic                             rd_val,
  input  logic [DAT_WIDTH-1:0]             rd_symbol,
  input  logic [7:0]                       rd_extra,
  input  logic [3:0]                       rd_extra_length,
  output logic                             out_vld,
  input  logic                             out_rdy,
  output logic                             out_sym_val,
  output logic [DAT_WIDTH-1:0]             out_symbol,
  output logic [7:0]                       out_extra,
  output logic [3:0]                       out_extra_length,
  output logic                             out_last,
  output logic [CREOLE_HC_SEQID_WIDTH-1:0] out_seq_id,
  output logic                             sa_st_read_done,
  output logic                             st_rd_busy,
  output logic [IDX_W-1:0]                 stat_sym_cnt,
  output logic [ST_RD_XTR_W-1:0]           stat_xtr_bits,
  output logic                             stat_xtr_mismatch
);

  e_st_rd_state                     state_q, state_nxt;
  logic [IDX_W-1:0]                 cnt_q, rd_idx_q, cnt_sat_c;
  logic [CREOLE_HC_SEQID_WIDTH-1:0] seq_q;
  logic                             done_q, busy_q, vld_q;
  s_st_rd_beat                      beat_q, beat_c;
  logic                             load_c, adv_c, last_c, acc_c, emit_c;

  assign cnt_sat_c = (sym_buf_wr_ptr > IDX_W'(MAX_SYMBOL_TABLE_DEPTH)) ?
                     IDX_W'(MAX_SYMBOL_TABLE_DEPTH) : sym_buf_wr_ptr;

  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:     if (sym_buf_full) state_nxt = LOAD;
      LOAD:     state_nxt = (st_build_error || (cnt_sat_c == '0)) ? DONE : EMIT;
      EMIT:     if (adv_c && last_c) state_nxt = DRAIN;
      DRAIN:    if (acc_c) state_nxt = DONE;
      DONE:     state_nxt = WAIT_CLR;
      WAIT_CLR: if (!sym_buf_full) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Datapath controls; an invalid entry is dropped unless it is the last one (marker beat).
  always_comb begin
    load_c = (state_q == LOAD);
    adv_c  = (state_q == EMIT) && (!vld_q || out_rdy);
    last_c = (rd_idx_q == (cnt_q - IDX_W'(1)));
    acc_c  = vld_q && out_rdy;
    emit_c = adv_c && (rd_val || last_c);
    beat_c = '{sym_val:      rd_val,
               symbol:       ST_RD_DAT_WIDTH'(rd_symbol),
               extra:        rd_extra,
               extra_length: rd_extra_length,
               last:         last_c};
  end

  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      seq_q    <= '0;
      rd_idx_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= (state_nxt == DONE);
      busy_q <= (state_nxt != IDLE);
      if (load_c) begin
        cnt_q    <= cnt_sat_c;
        seq_q    <= st_seq_id;
        rd_idx_q <= '0;
      end else if (adv_c && !last_c) begin
        rd_idx_q <= rd_idx_q + IDX_W'(1);
      end
    end
  end

  // Output register: holds while stalled, refills on every advance.
  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      beat_q <= '0;
    end else if (load_c) begin
      vld_q <= 1'b0;
    end else if (adv_c) begin
      vld_q <= emit_c;
      if (emit_c) beat_q <= beat_c;
    end else if (acc_c) begin
      vld_q <= 1'b0;
    end
  end

  assign rd_idx           = rd_idx_q;
  assign out_vld          = vld_q;
  assign out_sym_val      = beat_q.sym_val;
  assign out_symbol       = DAT_WIDTH'(beat_q.symbol);
  assign out_extra        = beat_q.extra;
  assign out_extra_length = beat_q.extra_length;
  assign out_last         = beat_q.last;
  assign out_seq_id       = seq_q;
  assign sa_st_read_done  = done_q;
  assign st_rd_busy       = busy_q;

`ifdef CR_HUF_COMP_ST_RD_SCHED_STATS_EN
  logic [IDX_W-1:0]       sym_cnt_q;
  logic [ST_RD_XTR_W-1:0] xtr_bits_q;
  logic                   mism_q, err_q;

  // Counters cover accepted valid-symbol beats; an error table leaves them all at zero.
  always_ff @(posedge clk_gated or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_q  <= '0;
      xtr_bits_q <= '0;
      mism_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (load_c) begin
      sym_cnt_q  <= '0;
      xtr_bits_q <= '0;
      mism_q     <= 1'b0;
      err_q      <= st_build_error;
    end else begin
      if (acc_c && beat_q.sym_val) begin
        sym_cnt_q  <= sym_cnt_q + IDX_W'(1);
        xtr_bits_q <= xtr_bits_q + ST_RD_XTR_W'(beat_q.extra_length);
      end
      if (state_q == DONE) mism_q <= !err_q && (xtr_bits_q != st_extra_size_store);
    end
  end

  assign stat_sym_cnt      = sym_cnt_q;
  assign stat_xtr_bits     = xtr_bits_q;
  assign stat_xtr_mismatch = mism_q;
`else
  logic unused_xtr_c;
  assign unused_xtr_c      = ^st_extra_size_store;
  assign stat_sym_cnt      = '0;
  assign stat_xtr_bits     = '0;
  assign stat_xtr_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_cr_huf_comp_st_rd_sched.sv
// Scoreboard bench for the symbol-table read-out scheduler (default and STATS_EN builds).
module tb_cr_huf_comp_st_rd_sched;
  import cr_huf_comp_st_rd_sched_pkg::*;

  localparam int unsigned IDX_W = 10;
  localparam int unsigned DW    = 10;
  localparam int unsigned SW    = CREOLE_HC_SEQID_WIDTH;
  localparam int unsigned XW    = ST_RD_XTR_W;
  localparam int          DEPTH = 584;

  logic             clk_gated = 1'b0;
  logic             rst_n;
  logic             sym_buf_full;
  logic [IDX_W-1:0] sym_buf_wr_ptr;
  logic             st_build_error;
  logic [SW-1:0]    st_seq_id;
  logic [XW-1:0]    st_extra_size_store;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_val;
  logic [DW-1:0]    rd_symbol;
  logic [7:0]       rd_extra;
  logic [3:0]       rd_extra_length;
  logic             out_vld, out_rdy, out_sym_val, out_last;
  logic [DW-1:0]    out_symbol;
  logic [7:0]       out_extra;
  logic [3:0]       out_extra_length;
  logic [SW-1:0]    out_seq_id;
  logic             sa_st_read_done, st_rd_busy, stat_xtr_mismatch;
  logic [IDX_W-1:0] stat_sym_cnt;
  logic [XW-1:0]    stat_xtr_bits;

  logic          mem_val [1024];
  logic [DW-1:0] mem_sym [1024];
  logic [7:0]    mem_ext [1024];
  logic [3:0]    mem_elen[1024];

  assign rd_val          = mem_val[rd_idx];
  assign rd_symbol       = mem_sym[rd_idx];
  assign rd_extra        = mem_ext[rd_idx];
  assign rd_extra_length = mem_elen[rd_idx];

  cr_huf_comp_st_rd_sched dut (
    .clk_gated(clk_gated), .rst_n(rst_n), .sym_buf_full(sym_buf_full),
    .sym_buf_wr_ptr(sym_buf_wr_ptr), .st_build_error(st_build_error), .st_seq_id(st_seq_id),
    .st_extra_size_store(st_extra_size_store), .rd_idx(rd_idx), .rd_val(rd_val),
    .rd_symbol(rd_symbol), .rd_extra(rd_extra), .rd_extra_length(rd_extra_length),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_sym_val(out_sym_val), .out_symbol(out_symbol),
    .out_extra(out_extra), .out_extra_length(out_extra_length), .out_last(out_last),
    .out_seq_id(out_seq_id), .sa_st_read_done(sa_st_read_done), .st_rd_busy(st_rd_busy),
    .stat_sym_cnt(stat_sym_cnt), .stat_xtr_bits(stat_xtr_bits), .stat_xtr_mismatch(stat_xtr_mismatch)
  );

  always #5 clk_gated = ~clk_gated;

  int cyc = 0;
  always @(posedge clk_gated) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pk(input logic [SW-1:0] s, input logic l, input logic v,
                                     input logic [DW-1:0] sy, input logic [7:0] e, input logic [3:0] el);
    return {s, l, v, sy, e, el};
  endfunction

  logic [31:0] exp_q[$];
  int acc_cnt = 0, vld_cnt = 0, done_cnt = 0;
  int tbl_acc_base = 0, first_acc_cyc = 0, last_acc_cyc = 0;
  int stall_at = -1, stall_left = 0;
  bit rdy_hold = 1'b0;
  bit held = 1'b0;
  logic [31:0] held_val;

  // Monitor: sampled mid-cycle; an accept here completes on the next rising edge.
  always @(negedge clk_gated) begin
    logic [31:0] cur;
    cur = pk(out_seq_id, out_last, out_sym_val, out_symbol, out_extra, out_extra_length);
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (out_vld) begin
        vld_cnt++;
        if (held) chk("stall_stable", cur, held_val);
        held     = !out_rdy;
        held_val = cur;
      end else begin
        held = 1'b0;
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else                   chk("beat", cur, exp_q.pop_front());
        if (acc_cnt == tbl_acc_base) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        acc_cnt++;
      end
      if (sa_st_read_done) done_cnt++;
    end
  end

  // Consumer ready: optional stall on a chosen beat, or held low entirely.
  always @(posedge clk_gated) begin
    #1;
    if (rdy_hold) out_rdy = 1'b0;
    else if (stall_left > 0 && out_vld && acc_cnt == stall_at) begin
      out_rdy = 1'b0;
      stall_left--;
    end else out_rdy = 1'b1;
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      mem_val[i] = 1'b0; mem_sym[i] = '0; mem_ext[i] = '0; mem_elen[i] = '0;
    end
  endtask

  task automatic set_ent(input int i, input logic v, input int sy, input int el);
    mem_val[i]  = v;
    mem_sym[i]  = DW'(sy);
    mem_ext[i]  = 8'($urandom_range(0, 255));
    mem_elen[i] = 4'(el);
  endtask

  task automatic run_table(input int ptr, input bit err, input logic [SW-1:0] seq, input int stall,
                           input int hold, input logic [XW-1:0] xtr_exp, input bit b2b);
    int cnt, n_exp, scnt, bits, d_base, v_base, c0, dcyc;
    bit got, mm;
    cnt = (ptr > DEPTH) ? DEPTH : ptr;
    n_exp = 0; scnt = 0; bits = 0; c0 = 0; dcyc = 0;
    if (!err) begin
      for (int i = 0; i < cnt; i++) begin
        if (mem_val[i] || i == cnt - 1) begin
          exp_q.push_back(pk(seq, i == cnt - 1, mem_val[i], mem_sym[i], mem_ext[i], mem_elen[i]));
          n_exp++;
          if (mem_val[i]) begin scnt++; bits += int'(mem_elen[i]); end
        end
      end
    end
    bits = bits & 32'h1fff;
    @(posedge clk_gated); #1;
    d_base = done_cnt; v_base = vld_cnt; tbl_acc_base = acc_cnt;
    stall_at = acc_cnt + 1; stall_left = stall;
    sym_buf_wr_ptr = IDX_W'(ptr); st_seq_id = seq; st_build_error = err;
    st_extra_size_store = xtr_exp; sym_buf_full = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk_gated);
      if (i == 0) c0 = cyc;
      if (sa_st_read_done) begin got = 1'b1; dcyc = cyc; end
      if (i == 2) begin sym_buf_wr_ptr = IDX_W'(7); st_seq_id = ~seq; end
    end
    chk("done_seen", got, 1);
    if (got) begin
      if (n_exp > 0) chk("done_after_last_accept", dcyc - last_acc_cyc, 1);
      else           chk("done_after_full", dcyc - c0, 2);
    end
    repeat (1 + hold) @(posedge clk_gated);
    #1 sym_buf_full = 1'b0; st_build_error = 1'b0;
    if (!b2b) begin
      repeat (3) @(negedge clk_gated);
      chk("busy_idle", st_rd_busy, 0);
    end
    chk("done_once", done_cnt - d_base, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("rd_idx_end", rd_idx, (err || cnt == 0) ? 0 : cnt - 1);
    if (n_exp == 0) chk("no_vld", vld_cnt - v_base, 0);
    mm = !err && (bits != int'(xtr_exp));
`ifdef CR_HUF_COMP_ST_RD_SCHED_STATS_EN
    chk("stat_sym_cnt", stat_sym_cnt, err ? 0 : scnt);
    chk("stat_xtr_bits", stat_xtr_bits, err ? 0 : bits);
    chk("stat_xtr_mismatch", stat_xtr_mismatch, mm);
`else
    chk("stat_zero", {stat_sym_cnt, stat_xtr_bits, stat_xtr_mismatch}, {1'b0, mm} & 2'b00);
`endif
    exp_q.delete();
  endtask

  initial begin
    int d_base;
    rst_n = 1'b0; sym_buf_full = 1'b0; sym_buf_wr_ptr = '0; st_build_error = 1'b0;
    st_seq_id = '0; st_extra_size_store = '0; out_rdy = 1'b1;
    clear_mem();
    repeat (3) @(negedge clk_gated);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_done", sa_st_read_done, 0);
    chk("rst_busy", st_rd_busy, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_payload", {out_sym_val, out_symbol, out_extra, out_extra_length, out_last, out_seq_id}, 0);
    chk("rst_stats", {stat_sym_cnt, stat_xtr_bits, stat_xtr_mismatch}, 0);
    @(posedge clk_gated); #1 rst_n = 1'b1;

    // Four valid entries at full rate
    clear_mem();
    for (int i = 0; i < 4; i++) set_ent(i, 1'b1, 10 + i, i + 1);
    run_table(4, 1'b0, 8'h11, 0, 0, 13'd10, 1'b0);
    chk("throughput", last_acc_cyc - first_acc_cyc, 3);

    // Sparse table ending in an invalid marker
    clear_mem();
    set_ent(0, 1'b1, 100, 2); set_ent(1, 1'b0, 101, 3); set_ent(2, 1'b1, 102, 5);
    set_ent(3, 1'b0, 103, 1); set_ent(4, 1'b0, 104, 6);
    run_table(5, 1'b0, 8'h22, 0, 0, 13'd7, 1'b0);

    // Consumer stalls three cycles on the second beat
    clear_mem();
    for (int i = 0; i < 3; i++) set_ent(i, 1'b1, 200 + i, 2);
    run_table(3, 1'b0, 8'h33, 3, 0, 13'd5, 1'b0);

    // Build error: discarded, full held an extra cycle
    clear_mem();
    for (int i = 0; i < 100; i++) set_ent(i, 1'b1, i, 1);
    run_table(100, 1'b1, 8'h44, 0, 1, 13'd0, 1'b0);

    // Empty table followed back-to-back by a new one
    clear_mem();
    run_table(0, 1'b0, 8'h55, 0, 0, 13'd0, 1'b1);
    for (int i = 0; i < 4; i++) set_ent(i, 1'b1, 300 + i, 1);
    run_table(4, 1'b0, 8'h66, 0, 0, 13'd4, 1'b0);

    // Extra-bit totals matching and not matching the stored size
    clear_mem();
    set_ent(0, 1'b1, 1, 3); set_ent(1, 1'b1, 2, 4); set_ent(2, 1'b1, 3, 0);
    run_table(3, 1'b0, 8'h77, 0, 0, 13'd7, 1'b0);
    run_table(3, 1'b0, 8'h78, 0, 0, 13'd8, 1'b0);

    // Out-of-range write pointer saturates to the buffer depth
    clear_mem();
    for (int i = 0; i < DEPTH; i++) set_ent(i, 1'($urandom_range(0, 7) == 0), i, 1);
    mem_val[DEPTH-1] = 1'b0;
    run_table(1000, 1'b0, 8'h88, 0, 0, 13'd0, 1'b0);

    // Reset while a beat is pending
    clear_mem();
    for (int i = 0; i < 6; i++) set_ent(i, 1'b1, 400 + i, 1);
    rdy_hold = 1'b1;
    @(posedge clk_gated); #1;
    d_base = done_cnt;
    sym_buf_wr_ptr = IDX_W'(6); st_seq_id = 8'h99; sym_buf_full = 1'b1;
    repeat (5) @(negedge clk_gated);
    chk("vld_before_rst", out_vld, 1);
    @(posedge clk_gated); #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", out_vld, 0);
    chk("rst_mid_busy", st_rd_busy, 0);
    sym_buf_full = 1'b0; rdy_hold = 1'b0;
    @(posedge clk_gated); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk_gated);
    chk("rst_mid_no_done", done_cnt - d_base, 0);
    chk("rst_mid_idle", st_rd_busy, 0);

    // Recovery after reset
    clear_mem();
    for (int i = 0; i < 3; i++) set_ent(i, 1'b1, 500 + i, 2);
    run_table(3, 1'b0, 8'hab, 0, 0, 13'd6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cr_huf_comp_st_rd_sched.md
Name: cr_huf_comp_st_rd_sched

Overview:
Read-out scheduler for the latched Huffman symbol-table buffer. When the symbol-table queue reports a full buffer, this block walks entries 0..wr_ptr-1 one per cycle through an indexed read port. It streams them to the symbol assembler over a valid/ready handshake. It then pulses sa_st_read_done to release the buffer. Build-error tables are discarded without emission.

Parameters:
DAT_WIDTH, 10, symbol width carried on the output
MAX_SYMBOL_TABLE_DEPTH, 584, buffer entries; IDX_W = $clog2(MAX_SYMBOL_TABLE_DEPTH+1)

Ports:
clk_gated  in  1  clock
rst_n  in  1  async active-low reset
sym_buf_full  in  1  buffer holds a complete table
sym_buf_wr_ptr  in  IDX_W  entry count, 0..MAX_SYMBOL_TABLE_DEPTH
st_build_error  in  1  table build failed
st_seq_id  in  CREOLE_HC_SEQID_WIDTH  table sequence id
st_extra_size_store  in  CREOLE_HC_SMALL_TABLE_XTR_BIT_SIZE+1  expected extra-bit total
rd_idx  out  IDX_W  entry index; the external mux returns rd_* in the same cycle
rd_val, rd_symbol, rd_extra, rd_extra_length  in  1/DAT_WIDTH/8/4  selected entry
out_vld  out  1  beat valid
out_rdy  in  1  consumer accepts
out_sym_val, out_symbol, out_extra, out_extra_length, out_last, out_seq_id  out  1/DAT_WIDTH/8/4/1/SEQID  beat payload
sa_st_read_done  out  1  one-cycle release pulse
st_rd_busy  out  1  state != IDLE
stat_sym_cnt, stat_xtr_bits, stat_xtr_mismatch  out  IDX_W/XTR+1/1  optional statistics

Behaviour:
- Reset: all outputs 0, rd_idx 0, state IDLE.
- Domain: sampled on clk_gated. The gate opens while sym_buf_full=1, so every transition that depends on the buffer occurs while full is high.
- IDLE: on sym_buf_full=1 → LOAD.
- LOAD (1 cycle): capture cnt=wr_ptr and seq=st_seq_id; rd_idx=0.
  - st_build_error=1 → DONE.
  - cnt=0 → DONE.
  - otherwise → EMIT.
- EMIT:
  - Advance condition: !out_vld || out_rdy. When it holds, the output register loads the entry at rd_idx and rd_idx increments.
  - Entries with rd_val=0 load nothing and set out_vld=0, except index cnt-1.
  - Index cnt-1 is always emitted, with out_last=1 and out_sym_val=rd_val (marker beat when the entry is invalid).
  - After loading index cnt-1 → DRAIN.
- Output register:
  - Payload is stable while out_vld=1 and out_rdy=0.
  - Throughput is 1 beat/cycle with out_rdy held at 1.
  - Latency is rd_idx → out_vld 1 cycle.
- DRAIN: wait for out_vld && out_rdy on the last beat → DONE.
- DONE: sa_st_read_done=1 for exactly 1 cycle → WAIT_CLR.
- WAIT_CLR: stay until sym_buf_full=0 → IDLE. This blocks retrigger on a stale full. A new table is accepted no earlier than the second cycle after the done pulse.
- Once LOAD has run, changes to sym_buf_wr_ptr or st_seq_id are ignored until IDLE. out_seq_id is the value captured in LOAD.
- Reset mid-table: immediate return to IDLE with out_vld=0 and no done pulse. The queue is reset by the same rst_n.
- rd_idx never exceeds cnt-1. wr_ptr is never above DEPTH; an out-of-range value saturates to DEPTH.

Optional Feature:
CR_HUF_COMP_ST_RD_SCHED_STATS_EN
- Defined:
  - stat_sym_cnt counts accepted beats with out_sym_val=1.
  - stat_xtr_bits sums out_extra_length over those beats.
  - Both clear in LOAD.
  - In DONE, stat_xtr_mismatch is set to (stat_xtr_bits != st_extra_size_store) and held until the next LOAD.
  - All three are 0 for an error table.
- Undefined: all three stat outputs tie to 0 and no counters are built.

Decomposition:
- cr_huf_compPKG adds:
  - e_st_rd_state enum {IDLE, LOAD, EMIT, DRAIN, DONE, WAIT_CLR}
  - s_st_rd_beat struct {sym_val, symbol, extra, extra_length, last}
- Single module; no sub-module. The output register is a small always_ff inside the block.

Test Plan:
- wr_ptr=4, all val=1, symbols 10,11,12,13, out_rdy=1 → 4 beats on consecutive cycles, out_last on 13, done pulse 1 cycle after the last accept.
- wr_ptr=5, val=1,0,1,0,0 → beats idx0, idx2, then marker idx4 with sym_val=0, last=1; done once.
- wr_ptr=3, out_rdy low for 3 cycles on beat 2 → payload held stable, no beat lost or duplicated, done after the final accept.
- st_build_error=1, wr_ptr=100 → no out_vld, done exactly 2 cycles after full rises; sym_buf_full held 1 extra cycle → no second done.
- wr_ptr=0 → no beats, single done; back-to-back table with full re-asserted 2 cycles after done → second table fully emitted with the new seq_id.
- STATS_EN, extra_length 3,4,0, expected size 7 → stat_xtr_bits=7, mismatch=0; expected 8 → mismatch=1. rst_n dropped mid-EMIT → out_vld=0 and IDLE on the next edge.
